// File: rtl/que_slot_pkg.sv
// Shared types and constants for the queue-slot round-robin scheduler.
// Push words are 9 bits wide: bit 8 flags the first byte of a packet, bits 7:0 carry data.
package que_slot_pkg;

    localparam int QUE_SLOT_WORD_WIDTH = 9;
    localparam int QUE_SLOT_FIRST_BIT  = 8;

    typedef enum logic [2:0] {
        S_IDLE,
        S_GRANT,
        S_WAIT_START,
        S_FORWARD,
        S_HOLDOFF
    } que_slot_sched_state_type;

endpackage

// File: rtl/que_slot_rr_picker.sv
// Combinational round-robin find-first-set: searches upward from last_grant+1,
// wrapping, over the request bits that are not masked.
module que_slot_rr_picker #(
    parameter int  NUM_SLOTS = 4,
    localparam int IDX_W     = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic [NUM_SLOTS-1:0] req_i,
    input  logic [NUM_SLOTS-1:0] mask_i,
    input  logic [IDX_W-1:0]     last_grant_i,
    output logic                 found_o,
    output logic [IDX_W-1:0]     index_o
);

    logic [NUM_SLOTS-1:0] eligible;
    int                   cand;

    assign eligible = req_i & ~mask_i;

    // Walk from the farthest offset down so the nearest eligible slot is written last.
    always_comb begin
        found_o = 1'b0;
        index_o = '0;
        cand    = 0;
        for (int k = NUM_SLOTS; k >= 1; k--) begin
            cand = int'(last_grant_i) + k;
            if (cand >= NUM_SLOTS) begin
                cand = cand - NUM_SLOTS;
            end
            if (eligible[cand]) begin
                found_o = 1'b1;
                index_o = IDX_W'(cand);
            end
        end
    end

endmodule

// File: rtl/que_slot_scheduler.sv
// Round-robin scheduler granting one slot handler at a time and forwarding its
// push words to the shared egress FIFO until the slot closes its streaming window.
module que_slot_scheduler
    import que_slot_pkg::*;
#(
    parameter int  NUM_SLOTS      = 4,
    parameter int  TIMEOUT_CYCLES = 16,
    localparam int IDX_W          = (NUM_SLOTS > 1) ? $clog2(NUM_SLOTS) : 1
) (
    input  logic                                     clock,
    input  logic                                     reset_n,
    input  logic [NUM_SLOTS-1:0]                     slot_ready,
    input  logic [NUM_SLOTS-1:0]                     slot_push_data_ready,
    input  logic [NUM_SLOTS*QUE_SLOT_WORD_WIDTH-1:0] slot_push_data,
    input  logic [NUM_SLOTS-1:0]                     slot_push_data_valid,
    input  logic                                     downstream_ready,
    output logic [NUM_SLOTS-1:0]                     slot_enable,
    output logic [QUE_SLOT_WORD_WIDTH-1:0]           out_data,
    output logic                                     out_data_valid,
    output logic [IDX_W-1:0]                         grant_index,
    output logic                                     busy,
    output logic                                     packet_done,
    output logic                                     timeout_error
);

    que_slot_sched_state_type       state_q;
    logic [IDX_W-1:0]               grant_q;
    logic [IDX_W-1:0]               last_grant_q;
    logic                           after_holdoff_q;
    logic [7:0]                     timer_q;
    logic [NUM_SLOTS-1:0]           slot_enable_q;
    logic [QUE_SLOT_WORD_WIDTH-1:0] out_data_q;
    logic                           out_valid_q;
    logic                           packet_done_q;
    logic                           timeout_error_q;

    logic [QUE_SLOT_WORD_WIDTH-1:0] slot_word [NUM_SLOTS];
    logic [NUM_SLOTS-1:0]           rr_mask;
    logic                           pick_found;
    logic [IDX_W-1:0]               pick_index;
    logic                           sel_ready;
    logic                           sel_valid;

    for (genvar gi = 0; gi < NUM_SLOTS; gi++) begin : g_unpack
        assign slot_word[gi] = slot_push_data[gi*QUE_SLOT_WORD_WIDTH +: QUE_SLOT_WORD_WIDTH];
    end

    // Hide the just-finished slot for one arbitration cycle while its ready advert decays.
    assign rr_mask   = after_holdoff_q ? (NUM_SLOTS'(1) << last_grant_q) : '0;
    assign sel_ready = slot_push_data_ready[grant_q];
    assign sel_valid = slot_push_data_valid[grant_q];

    que_slot_rr_picker #(
        .NUM_SLOTS (NUM_SLOTS)
    ) u_picker (
        .req_i        (slot_ready),
        .mask_i       (rr_mask),
        .last_grant_i (last_grant_q),
        .found_o      (pick_found),
        .index_o      (pick_index)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= S_IDLE;
            grant_q         <= '0;
            last_grant_q    <= IDX_W'(NUM_SLOTS - 1);
            after_holdoff_q <= 1'b0;
            timer_q         <= '0;
            slot_enable_q   <= '0;
            out_data_q      <= '0;
            out_valid_q     <= 1'b0;
            packet_done_q   <= 1'b0;
            timeout_error_q <= 1'b0;
        end else begin
            slot_enable_q   <= '0;
            out_valid_q     <= 1'b0;
            packet_done_q   <= 1'b0;
            timeout_error_q <= 1'b0;
            after_holdoff_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (downstream_ready && pick_found) begin
                        grant_q       <= pick_index;
                        slot_enable_q <= NUM_SLOTS'(1) << pick_index;
                        state_q       <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    timer_q <= 8'(TIMEOUT_CYCLES);
                    state_q <= S_WAIT_START;
                end
                S_WAIT_START: begin
                    if (sel_ready) begin
                        state_q <= S_FORWARD;
                    end else begin
                        timer_q <= timer_q - 8'd1;
                        if (timer_q <= 8'd1) begin
                            timeout_error_q <= 1'b1;
                            last_grant_q    <= grant_q;
                            state_q         <= S_IDLE;
                        end
                    end
                end
                S_FORWARD: begin
                    if (sel_ready) begin
                        if (sel_valid) begin
                            out_valid_q <= 1'b1;
                            out_data_q  <= slot_word[grant_q];
                        end
                    end else begin
                        packet_done_q <= 1'b1;
                        last_grant_q  <= grant_q;
                        state_q       <= S_HOLDOFF;
                    end
                end
                S_HOLDOFF: begin
                    after_holdoff_q <= 1'b1;
                    state_q         <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign slot_enable    = slot_enable_q;
    assign out_data       = out_data_q;
    assign out_data_valid = out_valid_q;
    assign grant_index    = grant_q;
    assign busy           = (state_q != S_IDLE);
    assign packet_done    = packet_done_q;
    assign timeout_error  = timeout_error_q;

endmodule

// File: tb/tb_que_slot_scheduler.sv
// Bench for que_slot_scheduler: directed scenarios with literal expectations plus
// randomized slot-handler traffic, all compared every cycle against a behavioural model.
`timescale 1ns/1ps
module tb_que_slot_scheduler;

    localparam int N   = 4;
    localparam int TMO = 16;
    localparam int IW  = 2;

    logic           clock = 1'b0;
    logic           reset_n = 1'b0;
    logic [N-1:0]   sr, spdr, svld;
    logic [N*9-1:0] sdata;
    logic           ds;
    logic [N-1:0]   en;
    logic [8:0]     odata;
    logic           ovalid, busy, done, terr;
    logic [IW-1:0]  gidx;

    que_slot_scheduler #(.NUM_SLOTS(N), .TIMEOUT_CYCLES(TMO)) dut (
        .clock                (clock),
        .reset_n              (reset_n),
        .slot_ready           (sr),
        .slot_push_data_ready (spdr),
        .slot_push_data       (sdata),
        .slot_push_data_valid (svld),
        .downstream_ready     (ds),
        .slot_enable          (en),
        .out_data             (odata),
        .out_data_valid       (ovalid),
        .grant_index          (gidx),
        .busy                 (busy),
        .packet_done          (done),
        .timeout_error        (terr)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_fail   = 0;

    // Model: which phase of a grant we are in, and what the outputs must be.
    localparam int P_IDLE = 0, P_GRANT = 1, P_WAIT = 2, P_FWD = 3, P_HOLD = 4;
    int         m_phase, m_last, m_waited;
    bit         m_fresh_idle;
    logic [N-1:0] x_en;
    logic [8:0] x_data;
    logic       x_valid, x_busy, x_done, x_terr;
    int         x_gidx;

    // Random slot-handler emulation.
    localparam int H_IDLE = 0, H_READY = 1, H_DELAY = 2, H_STREAM = 3, H_LAG = 4;
    int hs_ph [N];
    int hs_cnt [N];

    logic [8:0] pkt [8];
    int order [5] = '{0, 1, 2, 3, 0};

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_phase = P_IDLE; m_last = N - 1; m_waited = 0; m_fresh_idle = 1'b0;
        x_en = '0; x_data = '0; x_valid = 1'b0; x_busy = 1'b0;
        x_done = 1'b0; x_terr = 1'b0; x_gidx = 0;
    endtask

    task automatic model_step();
        int prev;
        int pick;
        int c;
        prev = m_phase;
        x_en = '0; x_done = 1'b0; x_terr = 1'b0; x_valid = 1'b0;
        case (m_phase)
            P_IDLE: begin
                pick = -1;
                for (int k = 1; k <= N; k++) begin
                    c = (m_last + k) % N;
                    if (pick < 0 && sr[c] && !(m_fresh_idle && c == m_last)) pick = c;
                end
                if (ds && pick >= 0) begin
                    x_gidx = pick; x_en[pick] = 1'b1; m_phase = P_GRANT;
                end
            end
            P_GRANT: begin m_waited = 0; m_phase = P_WAIT; end
            P_WAIT: begin
                if (spdr[x_gidx]) m_phase = P_FWD;
                else begin
                    m_waited++;
                    if (m_waited == TMO) begin x_terr = 1'b1; m_last = x_gidx; m_phase = P_IDLE; end
                end
            end
            P_FWD: begin
                if (spdr[x_gidx]) begin
                    if (svld[x_gidx]) begin x_valid = 1'b1; x_data = sdata[x_gidx*9 +: 9]; end
                end else begin
                    x_done = 1'b1; m_last = x_gidx; m_phase = P_HOLD;
                end
            end
            default: m_phase = P_IDLE;
        endcase
        m_fresh_idle = (prev == P_HOLD);
        x_busy = (m_phase != P_IDLE);
    endtask

    task automatic compare_all();
        chk("slot_enable", 32'(en), 32'(x_en));
        chk("out_data", 32'(odata), 32'(x_data));
        chk("out_data_valid", 32'(ovalid), 32'(x_valid));
        chk("grant_index", 32'(gidx), 32'(x_gidx));
        chk("busy", 32'(busy), 32'(x_busy));
        chk("packet_done", 32'(done), 32'(x_done));
        chk("timeout_error", 32'(terr), 32'(x_terr));
    endtask

    task automatic tick();
        model_step();
        @(posedge clock);
        @(negedge clock);
        compare_all();
    endtask

    task automatic clear_inputs();
        sr = '0; spdr = '0; svld = '0; sdata = '0; ds = 1'b1;
    endtask

    // Entered at the negedge of the enable cycle; leaves at the negedge of the holdoff cycle.
    task automatic serve(input int s, input int nw, input bit noise);
        spdr = '0; svld = '0;
        tick();
        spdr[s] = 1'b1;
        tick();
        for (int w = 0; w < nw; w++) begin
            for (int o = 0; o < N; o++) begin
                if (o != s && noise) begin
                    spdr[o] = 1'b1; svld[o] = 1'b1; sdata[o*9 +: 9] = 9'h155;
                end
            end
            svld[s] = 1'b1; sdata[s*9 +: 9] = pkt[w];
            tick();
            chk("serve_word", 32'(odata), 32'(pkt[w]));
            chk("serve_valid", 32'(ovalid), 32'd1);
        end
        spdr[s] = 1'b0; svld = '0;
        tick();
        chk("serve_done", 32'(done), 32'd1);
        chk("serve_nofwd", 32'(ovalid), 32'd0);
        $display("packet from slot %0d, %0d words", s, nw);
        spdr = '0; svld = '0;
    endtask

    task automatic gen_inputs();
        for (int i = 0; i < N; i++) begin
            case (hs_ph[i])
                H_IDLE: if ($urandom_range(0, 7) == 0) hs_ph[i] = H_READY;
                H_READY: begin
                    if (x_en[i]) begin
                        hs_ph[i]  = H_DELAY;
                        hs_cnt[i] = ($urandom_range(0, 7) == 0) ? int'($urandom_range(TMO - 1, TMO + 2))
                                                                 : int'($urandom_range(0, 4));
                    end else if ($urandom_range(0, 39) == 0) hs_ph[i] = H_IDLE;
                end
                H_DELAY: begin
                    if (hs_cnt[i] == 0) begin hs_ph[i] = H_STREAM; hs_cnt[i] = int'($urandom_range(1, 6)); end
                    else hs_cnt[i]--;
                end
                H_STREAM: if (hs_cnt[i] == 0) hs_ph[i] = H_LAG; else hs_cnt[i]--;
                default: hs_ph[i] = H_IDLE;
            endcase
            sr[i]   = (hs_ph[i] != H_IDLE);
            spdr[i] = (hs_ph[i] == H_STREAM) ? 1'b1 :
                      (hs_ph[i] == H_IDLE || hs_ph[i] == H_READY) ? ($urandom_range(0, 15) == 0) : 1'b0;
            svld[i] = (hs_ph[i] == H_STREAM) ? ($urandom_range(0, 3) != 0) : 1'($urandom_range(0, 1));
            sdata[i*9 +: 9] = 9'($urandom);
        end
        ds = ($urandom_range(0, 7) != 0);
    endtask

    initial begin
        clear_inputs();
        model_reset();
        for (int i = 0; i < N; i++) begin hs_ph[i] = H_IDLE; hs_cnt[i] = 0; end
        @(negedge clock);
        @(negedge clock);
        reset_n = 1'b1;
        compare_all();
        chk("reset_enable", 32'(en), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_grant", 32'(gidx), 32'd0);

        // Single slot, three words.
        sr = 4'b0001; tick();
        chk("single_enable", 32'(en), 32'b0001);
        sr = '0;
        pkt[0] = 9'h1AA; pkt[1] = 9'h0BB; pkt[2] = 9'h0CC;
        serve(0, 3, 1'b0);
        tick();
        chk("single_done_once", 32'(done), 32'd0);

        // Timeout on slot 2, slot 3 waiting behind it.
        sr = 4'b0100; tick();
        chk("tmo_grant2", 32'(en), 32'b0100);
        sr = 4'b1000; tick();
        for (int k = 1; k <= TMO; k++) begin
            tick();
            chk("tmo_pulse", 32'(terr), (k == TMO) ? 32'd1 : 32'd0);
        end
        tick();
        chk("tmo_next_slot3", 32'(en), 32'b1000);
        sr = '0; pkt[0] = 9'h111; pkt[1] = 9'h022;
        serve(3, 2, 1'b0);
        tick();

        // Backpressure then ready lag on slot 1.
        sr = 4'b0010; ds = 1'b0;
        for (int k = 0; k < 20; k++) begin
            tick();
            chk("bp_no_enable", 32'(en), 32'd0);
        end
        ds = 1'b1; tick();
        chk("bp_enable1", 32'(en), 32'b0010);
        pkt[0] = 9'h1E1; pkt[1] = 9'h0E2;
        serve(1, 2, 1'b0);
        tick();
        chk("lag_no_regrant_a", 32'(en), 32'd0);
        tick();
        chk("lag_no_regrant_b", 32'(en), 32'd0);
        sr = '0; tick();

        // Asynchronous reset during word 2 of a 5-word packet.
        sr = 4'b0001; tick();
        chk("rst_grant0", 32'(en), 32'b0001);
        sr = '0; tick();
        spdr[0] = 1'b1; tick();
        svld[0] = 1'b1; sdata[8:0] = 9'h1A1; tick();
        chk("rst_word1_valid", 32'(ovalid), 32'd1);
        sdata[8:0] = 9'h0A2;
        #2 reset_n = 1'b0;
        #1;
        chk("rst_valid_async", 32'(ovalid), 32'd0);
        chk("rst_busy_async", 32'(busy), 32'd0);
        chk("rst_enable_async", 32'(en), 32'd0);
        model_reset();
        compare_all();
        clear_inputs();
        @(negedge clock);
        reset_n = 1'b1;
        compare_all();
        sr = 4'b1111; tick();
        chk("rst_next_slot0", 32'(en), 32'b0001);

        // All slots contending, foreign slots streaming noise.
        for (int g = 0; g < 5; g++) begin
            chk("rr_order", 32'(en), 32'(1) << order[g]);
            chk("rr_index", 32'(gidx), 32'(order[g]));
            pkt[0] = 9'h100 | 9'(order[g] * 16 + g); pkt[1] = 9'(8'hF0 + g);
            serve(order[g], 2, 1'b1);
            tick();
            tick();
        end
        clear_inputs();

        // Randomized handler traffic.
        for (int c = 0; c < 4000; c++) begin
            gen_inputs();
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
